// File: rtl/l1route_src_sched_if.sv
// Source-side handshake bundle for l1route_src_sched.
// shift_err_o exists only when L1ROUTE_SHIFT_CHECK_EN is defined.
interface l1route_src_sched_if #(
  parameter int STRIDE_WIDTH          = 5,
  parameter int BITWIDTH_SHIFT_FACTOR = 6
);
  localparam int SW = STRIDE_WIDTH * BITWIDTH_SHIFT_FACTOR;

  logic          req0_i;
  logic [SW-1:0] shift0_i;
  logic          req1_i;
  logic [SW-1:0] shift1_i;
  logic          gnt0_o;
  logic          gnt1_o;
  logic          sw_in_src_o;
  logic [SW-1:0] stride_shift_factor_o;
  logic          route_valid_o;
  logic          route_src_o;
  logic          busy_o;
`ifdef L1ROUTE_SHIFT_CHECK_EN
  logic          shift_err_o;
`endif

  modport master (
    output req0_i, shift0_i, req1_i, shift1_i,
    input  gnt0_o, gnt1_o, sw_in_src_o,
    input  stride_shift_factor_o,
    input  route_valid_o, route_src_o, busy_o
`ifdef L1ROUTE_SHIFT_CHECK_EN
    , input shift_err_o
`endif
  );

  modport slave (
    input  req0_i, shift0_i, req1_i, shift1_i,
    output gnt0_o, gnt1_o, sw_in_src_o,
    output stride_shift_factor_o,
    output route_valid_o, route_src_o, busy_o
`ifdef L1ROUTE_SHIFT_CHECK_EN
    , output shift_err_o
`endif
  );
endinterface

// File: rtl/l1route_src_sched.sv
// Two-source burst-limited scheduler feeding a QSN routing network.
// Optional macro L1ROUTE_SHIFT_CHECK_EN zeroes out-of-range strides.
module l1route_src_sched #(
  parameter int STRIDE_UNIT_SIZE      = 51,
  parameter int STRIDE_WIDTH          = 5,
  parameter int BITWIDTH_SHIFT_FACTOR = 6,
  parameter int ROUTE_LATENCY         = 2,
  parameter int MAX_BURST             = 4
) (
  input  logic sys_clk,
  input  logic rstn,
  l1route_src_sched_if.slave bus
);
  localparam int SW = STRIDE_WIDTH * BITWIDTH_SHIFT_FACTOR;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int BF = BITWIDTH_SHIFT_FACTOR;
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  if (BITWIDTH_SHIFT_FACTOR < $clog2(STRIDE_UNIT_SIZE)) begin : g_bad_cfg
    $error("shift factor too narrow for STRIDE_UNIT_SIZE");
  end

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t                 state;
  logic [CW-1:0]          burst;
  logic                   last;
  logic [ROUTE_LATENCY:0] vld;
  logic [ROUTE_LATENCY:0] src;
  logic                   sw_src;
  logic [SW-1:0]          sf;
  logic                   gnt0, gnt1, gnt;
  logic                   r0, r1, burst_max;
  logic [SW-1:0]          sel, fix;
  logic                   bad;

  assign r0 = bus.req0_i;
  assign r1 = bus.req1_i;
  assign burst_max = (burst >= MAXB);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      IDLE: begin
        if (r0 && r1) begin
          gnt0 = last;
          gnt1 = !last;
        end else begin
          gnt0 = r0;
          gnt1 = r1;
        end
      end
      SERVE0: begin
        if (r0 && !(r1 && burst_max)) gnt0 = 1'b1;
        else gnt1 = r1;
      end
      SERVE1: begin
        if (r1 && !(r0 && burst_max)) gnt1 = 1'b1;
        else gnt0 = r0;
      end
      default: ;
    endcase
    if (!rstn) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign gnt = gnt0 | gnt1;

  always_comb begin
    sel = gnt1 ? bus.shift1_i : bus.shift0_i;
    fix = sel;
    bad = 1'b0;
`ifdef L1ROUTE_SHIFT_CHECK_EN
    for (int k = 0; k < STRIDE_WIDTH; k++) begin
      if (int'(sel[k*BF +: BF]) >= STRIDE_UNIT_SIZE) begin
        fix[k*BF +: BF] = '0;
        bad = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      burst  <= '0;
      last   <= 1'b1;
      sw_src <= 1'b0;
      sf     <= '0;
      vld    <= '0;
      src    <= '0;
    end else begin
      state <= gnt0 ? SERVE0 : (gnt1 ? SERVE1 : IDLE);
      // burst restarts at 1 whenever the granted source changes
      if (gnt0)
        burst <= (state == SERVE0) ?
                 (burst_max ? MAXB : burst + 1'b1) : CW'(1);
      else if (gnt1)
        burst <= (state == SERVE1) ?
                 (burst_max ? MAXB : burst + 1'b1) : CW'(1);
      else
        burst <= '0;
      if (gnt) begin
        last   <= gnt1;
        sw_src <= gnt1;
        sf     <= fix;
      end
      vld[0] <= gnt;
      src[0] <= gnt1;
      for (int i = 1; i <= ROUTE_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        src[i] <= src[i-1];
      end
    end
  end

`ifdef L1ROUTE_SHIFT_CHECK_EN
  logic err;
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) err <= 1'b0;
    else if (gnt && bad) err <= 1'b1;
  end
  assign bus.shift_err_o = err;
`else
  logic unused_bad;
  assign unused_bad = bad;
`endif

  assign bus.gnt0_o                = gnt0;
  assign bus.gnt1_o                = gnt1;
  assign bus.sw_in_src_o           = sw_src;
  assign bus.stride_shift_factor_o = sf;
  assign bus.route_valid_o         = vld[ROUTE_LATENCY];
  assign bus.route_src_o           = src[ROUTE_LATENCY];
  assign bus.busy_o                = r0 | r1 | (|vld);
endmodule

// File: doc/l1route_src_sched.md
L1ROUTE_SRC_SCHED -- requirements
Module: l1route_src_sched

Interface
REQ-001 SHALL have parameters: STRIDE_UNIT_SIZE, default 51, QSN permutation length; STRIDE_WIDTH, default 5, number of stride groups; BITWIDTH_SHIFT_FACTOR, default 6, shift-factor width; ROUTE_LATENCY, default 2, routing-network cycles from issue to output; MAX_BURST, default 4, maximum consecutive grants to one source while the other waits.
REQ-002 SHALL have ports (name direction width meaning): sys_clk in 1 clock; rstn in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: req0_i in 1 source-0 routing request; shift0_i in STRIDE_WIDTH*BITWIDTH_SHIFT_FACTOR source-0 per-stride shift factors, stride k at bits [k*BW +: BW].
REQ-004 SHALL have ports: req1_i in 1 source-1 routing request; shift1_i in STRIDE_WIDTH*BITWIDTH_SHIFT_FACTOR source-1 shift factors, same packing.
REQ-005 SHALL have ports: gnt0_o out 1, gnt1_o out 1, one-hot-or-zero acceptance strobes.
REQ-006 SHALL have ports: sw_in_src_o out 1 routing-network input selector; stride_shift_factor_o out STRIDE_WIDTH*BITWIDTH_SHIFT_FACTOR shift factors for the routing network.
REQ-007 SHALL have ports: route_valid_o out 1 routed data valid at the network output; route_src_o out 1 source of that data; busy_o out 1 pass in flight or requests pending.
REQ-008 SHALL use a single clock sys_clk and an asynchronous active-low reset rstn.

Function
REQ-009 SHALL implement FSM states IDLE, SERVE0, SERVE1; state equals the source granted in the current cycle, IDLE when none.
REQ-010 SHALL assert gnt_x_o combinationally in the cycle a request is accepted; a request is held by the requester until granted.
REQ-011 SHALL, with both requests high in IDLE, grant the source not served last (last-served pointer resets to 1, so source 0 wins first).
REQ-012 SHALL keep granting the current source every cycle while it requests, until burst count reaches MAX_BURST with the other source requesting, then switch and reset burst count to 1.
REQ-013 SHALL switch immediately when the current source drops its request and the other requests; SHALL enter IDLE when neither requests.
REQ-014 SHALL, on the edge after a grant in cycle t, register sw_in_src_o = granted source and stride_shift_factor_o = that source's shift vector sampled at t.
REQ-015 SHALL hold sw_in_src_o and stride_shift_factor_o unchanged in cycles with no grant.
REQ-016 SHALL assert route_valid_o for one cycle in cycle t+1+ROUTE_LATENCY for each grant in cycle t, with route_src_o = granted source, via a ROUTE_LATENCY+1 deep valid/source shift register; back-to-back grants produce back-to-back valids.
REQ-017 SHALL drive busy_o = req0_i | req1_i | any valid bit in the shift register.
REQ-018 SHALL saturate the burst counter at MAX_BURST (width clog2(MAX_BURST+1)).

Reset
REQ-019 SHALL on rstn low asynchronously set: state IDLE, gnt0_o=0, gnt1_o=0, sw_in_src_o=0, stride_shift_factor_o=0, route_valid_o=0, route_src_o=0, busy_o=req0_i|req1_i, burst count 0, last-served pointer 1, shift register cleared.
REQ-020 SHALL discard all in-flight passes on reset mid-operation; no route_valid_o after rstn deasserts for pre-reset grants.
REQ-021 SHALL issue no grant while rstn is low.

Configuration
REQ-022 SHALL support macro L1ROUTE_SHIFT_CHECK_EN: when defined, any stride field >= STRIDE_UNIT_SIZE in the granted vector is replaced by 0 in stride_shift_factor_o and sets sticky output shift_err_o (1 bit, cleared only by reset); when undefined, fields pass unmodified and shift_err_o is absent.

Verification
REQ-023 SHALL cover: reset release, req0_i high one cycle with shift0_i stride0=7 -> gnt0_o same cycle, sw_in_src_o=0 and stride0 factor 7 next cycle, route_valid_o=1 with route_src_o=0 three cycles after grant.
REQ-024 SHALL cover: both requests held from IDLE after reset -> grants 0,0,0,0,1,1,1,1,0 (MAX_BURST=4), never both grants high.
REQ-025 SHALL cover: req0_i held, req1_i low -> gnt0_o every cycle, route_valid_o continuous after 3-cycle latency.
REQ-026 SHALL cover: rstn pulsed low during two in-flight passes -> no route_valid_o afterwards, outputs at reset values.
REQ-027 SHALL cover (macro defined): shift1_i stride2=55 granted -> stride2 output 0, shift_err_o=1 and held until reset; macro undefined -> stride2 output 55.
